// File: rtl/temp_spi_reader.sv
// SPI master that periodically reads an LM70-family sensor and returns its top 8 bits.
// Optional build macro TEMP_SPI_AVG4_EN: output a signed 4-sample moving average.
module temp_spi_reader #(
  parameter int CLK_DIV       = 4,
  parameter int NBITS         = 8,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       sio,
  output logic       cs_n,
  output logic       sck,
  output logic       busy,
  output logic [7:0] temp_data,
  output logic       temp_valid
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SETUP    = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_SHIFT_LO = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NBITS + 1);
  localparam int PW = $clog2(SAMPLE_PERIOD);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_ALL  = BW'(NBITS);
  localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);

  logic [2:0]       state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d, shift_in_s;
  logic [PW-1:0]    period_q, period_d;
  logic             cs_n_q, sck_q, busy_q, valid_q;
  logic [7:0]       data_q, raw_s, data_s;
  logic             done_s;

  generate
    if (NBITS == 1) begin : g_shift1
      assign shift_in_s = sio;
    end else begin : g_shiftn
      assign shift_in_s = {shift_q[NBITS-2:0], sio};
    end
    // Short frames are sign-extended; long frames keep only their 8 MSBs.
    if (NBITS >= 8) begin : g_raw_msb
      assign raw_s = shift_q[NBITS-1 -: 8];
    end else begin : g_raw_sext
      assign raw_s = {{(8 - NBITS){shift_q[NBITS-1]}}, shift_q};
    end
  endgenerate

  // Next-state logic for the frame sequencer and its counters.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    period_d = period_q;
    case (state_q)
      ST_IDLE: begin
        if (start || (ena && (period_q == PER_LAST))) begin
          state_d = ST_SETUP;
          div_d   = '0;
          bit_d   = '0;
          shift_d = '0;
        end else if (ena) begin
          period_d = period_q + PW'(1);
        end else begin
          period_d = period_q;
        end
      end
      ST_SETUP: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT_HI;
          div_d   = '0;
          shift_d = shift_in_s;
          bit_d   = bit_q + BW'(1);
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          state_d = ST_SHIFT_LO;
          div_d   = '0;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_SHIFT_LO: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DW'(1);
        end else if (bit_q < BITS_ALL) begin
          state_d = ST_SHIFT_HI;
          div_d   = '0;
          shift_d = shift_in_s;
          bit_d   = bit_q + BW'(1);
        end else begin
          state_d  = ST_DONE;
          div_d    = '0;
          period_d = '0;
        end
      end
      ST_DONE: begin
        // The DONE cycle already counts toward the next automatic start.
        state_d  = ST_IDLE;
        period_d = ena ? PW'(1) : PW'(0);
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign done_s = (state_d == ST_DONE);

`ifdef TEMP_SPI_AVG4_EN
  logic [7:0] h0_q, h1_q, h2_q;
  logic       filled_q;
  logic [9:0] sum_s;

  function automatic logic [9:0] sx10(input logic [7:0] v);
    return {{2{v[7]}}, v};
  endfunction

  // Sum of the new reading and the three previous ones; the first reading stands in for all four.
  always_comb begin
    if (filled_q) begin
      sum_s = sx10(raw_s) + sx10(h0_q) + sx10(h1_q) + sx10(h2_q);
    end else begin
      sum_s = sx10(raw_s) + sx10(raw_s) + sx10(raw_s) + sx10(raw_s);
    end
    data_s = 8'(sum_s >> 2);
  end

  // Reading history, newest in h0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0_q     <= 8'h00;
      h1_q     <= 8'h00;
      h2_q     <= 8'h00;
      filled_q <= 1'b0;
    end else if (done_s) begin
      h0_q     <= raw_s;
      h1_q     <= filled_q ? h0_q : raw_s;
      h2_q     <= filled_q ? h1_q : raw_s;
      filled_q <= 1'b1;
    end else begin
      filled_q <= filled_q;
    end
  end
`else
  assign data_s = raw_s;
`endif

  // State, counters and registered pin/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      period_q <= '0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      cs_n_q   <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      sck_q    <= (state_d == ST_SHIFT_HI);
      busy_q   <= (state_d != ST_IDLE);
      valid_q  <= done_s;
      data_q   <= done_s ? data_s : data_q;
    end
  end

  assign cs_n       = cs_n_q;
  assign sck        = sck_q;
  assign busy       = busy_q;
  assign temp_data  = data_q;
  assign temp_valid = valid_q;

endmodule

// File: tb/tb_temp_spi_reader.sv
// Self-checking bench for temp_spi_reader: LM70 sensor model, vector table, random frames
// and hand-written timing sequences; also covers the TEMP_SPI_AVG4_EN build.
module tb_temp_spi_reader;
  localparam int P = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ena_a, start_a, start_b;
  logic       cs_n_a, sck_a, busy_a, temp_valid_a, sio_a;
  logic       cs_n_b, sck_b, busy_b, temp_valid_b, sio_b;
  logic [7:0] temp_data_a, temp_data_b;
  logic [15:0] word_a, word_b;
  int fall_a = 0;
  int fall_b = 0;
  int pass_cnt = 0;
  int total_cnt = 0;

  temp_spi_reader #(.CLK_DIV(4), .NBITS(8), .SAMPLE_PERIOD(P)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .start(start_a), .sio(sio_a),
    .cs_n(cs_n_a), .sck(sck_a), .busy(busy_a), .temp_data(temp_data_a), .temp_valid(temp_valid_a));

  temp_spi_reader #(.CLK_DIV(4), .NBITS(5), .SAMPLE_PERIOD(P)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(1'b0), .start(start_b), .sio(sio_b),
    .cs_n(cs_n_b), .sck(sck_b), .busy(busy_b), .temp_data(temp_data_b), .temp_valid(temp_valid_b));

  // Sensor: MSB presented when CS falls, next bit after each SCK falling edge.
  always @(negedge sck_a or posedge cs_n_a) if (cs_n_a) fall_a <= 0; else fall_a <= fall_a + 1;
  always @(negedge sck_b or posedge cs_n_b) if (cs_n_b) fall_b <= 0; else fall_b <= fall_b + 1;
  assign sio_a = (fall_a < 16) ? word_a[15 - fall_a] : 1'b0;
  assign sio_b = (fall_b < 16) ? word_b[15 - fall_b] : 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: top NBITS of the 16-bit word, reduced to 8 signed bits.
  function automatic logic [7:0] ref_raw(input logic [15:0] w, input int nbits);
    int s;
    s = int'($signed(w));
    s = (nbits >= 8) ? (s >>> 8) : (s >>> (16 - nbits));
    return s[7:0];
  endfunction

`ifdef TEMP_SPI_AVG4_EN
  int hist_a[$];
  function automatic logic [7:0] model_a(input logic [7:0] raw);
    int v, sum;
    v = int'($signed(raw));
    if (hist_a.size() == 0) repeat (3) hist_a.push_back(v);
    hist_a.push_back(v);
    while (hist_a.size() > 4) void'(hist_a.pop_front());
    sum = 0;
    foreach (hist_a[i]) sum += hist_a[i];
    sum = sum >>> 2;
    return sum[7:0];
  endfunction
  task automatic model_reset();
    hist_a.delete();
  endtask
`else
  function automatic logic [7:0] model_a(input logic [7:0] raw);
    return raw;
  endfunction
  task automatic model_reset();
  endtask
`endif

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic collect_a(output int lo, output int pulses, output int bz, output logic ok);
    logic prev;
    prev = 1'b0; lo = 0; pulses = 0; bz = 0; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (cs_n_a === 1'b0) lo++;
      if (busy_a === 1'b1) bz++;
      if (sck_a === 1'b1 && !prev) pulses++;
      prev = sck_a;
      if (temp_valid_a === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic frame_a(input string tag, input logic [7:0] exp_data);
    int lo, pulses, bz;
    logic ok;
    collect_a(lo, pulses, bz, ok);
    check({tag, "_done"}, ok, 1);
    check({tag, "_cs_low"}, lo, 68);
    check({tag, "_sck"}, pulses, 8);
    check({tag, "_busy"}, bz, 69);
    check({tag, "_data"}, temp_data_a, exp_data);
    @(negedge clk);
    check({tag, "_valid_1cyc"}, temp_valid_a, 0);
  endtask

  task automatic wait_cs_low(output int n);
    n = 0;
    while (n < 1200) begin
      @(negedge clk);
      n++;
      if (cs_n_a === 1'b0) break;
    end
  endtask

  typedef struct { logic [15:0] word; logic [7:0] raw; } vec_t;
  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n, lo, pulses, bz, prev_sck;
    logic ok;
    logic [15:0] w;
    vecs[0] = '{16'h3280, 8'h32};
    vecs[1] = '{16'hE700, 8'hE7};
    vecs[2] = '{16'h7FFF, 8'h7F};
    vecs[3] = '{16'h8000, 8'h80};
    vecs[4] = '{16'h0000, 8'h00};
    vecs[5] = '{16'hFF80, 8'hFF};
    vecs[6] = '{16'h0100, 8'h01};

    rst_n = 1'b0; ena_a = 1'b0; start_a = 1'b0; start_b = 1'b0;
    word_a = 16'h0000; word_b = 16'hA000;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n_a, 1);
    check("rst_sck", sck_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_data", temp_data_a, 8'h00);
    check("rst_valid", temp_valid_a, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      word_a = vecs[i].word;
      pulse_start_a();
      frame_a($sformatf("vec%0d", i), model_a(vecs[i].raw));
    end

    for (int i = 0; i < 8; i++) begin
      w = 16'($urandom);
      word_a = w;
      pulse_start_a();
      frame_a($sformatf("rand%0d", i), model_a(ref_raw(w, 8)));
    end

    // start pulses while busy must be neither accepted nor queued
    word_a = 16'h3280;
    pulse_start_a();
    repeat (20) begin
      start_a = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start_a = 1'b0;
    check("busy_mid", busy_a, 1);
    collect_a(lo, pulses, bz, ok);
    check("busy_frame_done", ok, 1);
    check("busy_frame_data", temp_data_a, model_a(8'h32));
    n = 0;
    repeat (100) begin @(negedge clk); if (cs_n_a === 1'b0) n++; end
    check("busy_no_queued", n, 0);

    // reset asserted during bit 3
    word_a = 16'h3280;
    pulse_start_a();
    prev_sck = 0; n = 0;
    for (int i = 0; i < 200; i++) begin
      if (sck_a === 1'b1 && prev_sck == 0) n++;
      prev_sck = int'(sck_a);
      if (n == 4) break;
      @(negedge clk);
    end
    check("midrst_reached_bit3", n, 4);
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", cs_n_a, 1);
    check("midrst_sck", sck_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_data", temp_data_a, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    word_a = 16'hE700;
    pulse_start_a();
    frame_a("after_rst", model_a(8'hE7));

    // automatic sampling from reset release, spacing, coincident start, ena drop mid-frame
    rst_n = 1'b0; ena_a = 1'b1; word_a = 16'hE700;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    wait_cs_low(n);
    check("auto_first_start", n, P);
    frame_a("auto1", model_a(8'hE7));
    wait_cs_low(n);
    check("auto_spacing", n + 1, P);
    frame_a("auto2", model_a(8'hE7));
    repeat (P - 2) @(negedge clk);
    check("coin_pre_idle", cs_n_a, 1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    ena_a = 1'b0;
    check("coin_started", cs_n_a, 0);
    frame_a("coin", model_a(8'hE7));
    n = 0;
    repeat (1100) begin @(negedge clk); if (cs_n_a === 1'b0) n++; end
    check("no_auto_after_ena_drop", n, 0);

    // NBITS=5 instance
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    lo = 0; pulses = 0; ok = 1'b0; prev_sck = 0;
    for (int i = 0; i < 200; i++) begin
      if (cs_n_b === 1'b0) lo++;
      if (sck_b === 1'b1 && prev_sck == 0) pulses++;
      prev_sck = int'(sck_b);
      if (temp_valid_b === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("n5_done", ok, 1);
    check("n5_cs_low", lo, 44);
    check("n5_sck", pulses, 5);
    check("n5_data", temp_data_b, ref_raw(word_b, 5));
    @(negedge clk);
    check("n5_valid_1cyc", temp_valid_b, 0);

`ifdef TEMP_SPI_AVG4_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    word_a = 16'h1000; pulse_start_a(); frame_a("avg0", 8'h10);
    word_a = 16'h2000; pulse_start_a(); frame_a("avg1", 8'h14);
    word_a = 16'h3000; pulse_start_a(); frame_a("avg2", 8'h1C);
    word_a = 16'h4000; pulse_start_a(); frame_a("avg3", 8'h28);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/temp_spi_reader.md
# temp_spi_reader

SPI master that periodically reads the LM70-family temperature sensor and presents the 8 MSBs (2 °C/LSB, two's complement) as a registered byte with a one-cycle valid strobe. It sits directly upstream of the monitor logic inside `digital_temp_monitor_top`. At the top level, `cs_n` drives `uio_out[0]`, `sck` drives `uio_out[1]` and `sio` is fed from `uio_in[2]`.

## Interface
- `CLK_DIV`, 4: clk cycles per SCK half-period; legal range is ≥1.
- `NBITS`, 8: number of sensor MSBs read per frame; legal range is 1..16.
- `SAMPLE_PERIOD`, 1000: clk cycles from one frame's end to the next automatic frame start; legal range is ≥2.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: when high, automatic sampling is allowed.
- `start` in 1: one-shot frame request, accepted only in IDLE.
- `sio` in 1: sensor serial data. The sensor updates it on SCK falling edges while CS is low.
- `cs_n` out 1: sensor chip select, active low.
- `sck` out 1: serial clock; idles low.
- `busy` out 1: high in every state except IDLE.
- `temp_data` out 8: last completed reading, sign-extended to 8 bits when NBITS<8.
- `temp_valid` out 1: one-cycle pulse when `temp_data` updates.

## Operation
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, DONE.
- IDLE
  - `cs_n`=1, `sck`=0; the period counter increments each cycle while `ena`=1.
  - Go to SETUP when `start`=1, or when `ena`=1 and the counter reaches SAMPLE_PERIOD-1.
  - If both conditions occur in the same cycle, start one frame only.
- SETUP
  - `cs_n`=0 for CLK_DIV cycles. The sensor loads its register and presents the MSB.
  - Then go to SHIFT_HI.
- SHIFT_HI
  - On entry, `sck`=1 and `sio` is sampled into the shift register MSB-first on that same clk edge.
  - Stays in SHIFT_HI for CLK_DIV cycles, then goes to SHIFT_LO.
- SHIFT_LO
  - `sck`=0 for CLK_DIV cycles; the sensor shifts on this falling edge.
  - If bit count < NBITS, go to SHIFT_HI; otherwise go to DONE.
- DONE (1 cycle)
  - `cs_n`=1; `temp_data` updated; `temp_valid`=1.
  - Period counter cleared; go to IDLE.
- `ena` falling mid-frame: the frame completes normally; only later automatic starts are suppressed.
- `start` outside IDLE: ignored, not queued.
- Reset (including mid-frame): immediately `cs_n`=1, `sck`=0, `busy`=0, `temp_data`=0x00, `temp_valid`=0, counters and shift register cleared, state IDLE.

## Timing
- Let T0 be the clk edge entering SETUP; `cs_n` falls at T0.
- Rising SCK edge for bit k (k=0..NBITS-1): T0 + CLK_DIV + 2·k·CLK_DIV; `sio` is sampled on that edge.
- DONE edge: T0 + CLK_DIV·(2·NBITS+1); `cs_n` rises, `temp_valid` pulses, `temp_data` is valid from this edge.
- Defaults (D=4, N=8): 68-cycle frame, SCK = clk/8.
- Automatic frame spacing: SAMPLE_PERIOD cycles from the DONE edge to the next T0.
- With default period, the first automatic frame starts 1000 cycles after reset release when `ena`=1.
- `busy` is registered: high from T0 through the DONE cycle inclusive.

## Configuration
- `TEMP_SPI_AVG4_EN` defined: `temp_data` is the signed 4-sample moving average (sum of the last 4 raw readings, arithmetic shift right 2, truncated toward −∞).
  - The first reading after reset fills all four history slots.
  - `temp_valid` timing is unchanged.
- `TEMP_SPI_AVG4_EN` undefined: `temp_data` is the raw reading; no history registers.

## Test plan
- Sensor model 16'h3280, `ena`=0, pulse `start` → `cs_n` low for exactly 68 cycles, 8 SCK pulses, `temp_data`=0x32 with `temp_valid` high 1 cycle on the DONE edge.
- Sensor 16'hE700 (−50 °C), `ena`=1, no `start` → first frame starts 1000 cycles after reset release; `temp_data`=0xE7; next frame starts exactly 1000 cycles after DONE.
- Assert `rst_n`=0 during bit 3 → `cs_n`=1, `sck`=0 and `temp_data`=0x00 at once; after release, the next frame reads a full 8 bits correctly.
- Pulse `start` repeatedly while `busy`=1 → no extra frames; `start` in the same cycle as the period expiry → exactly one frame.
- NBITS=5, sensor 16'hA000 → 5 SCK pulses, frame 44 cycles, `temp_data`=0xF4 (sign-extended 10100).
- `TEMP_SPI_AVG4_EN`: readings 0x10, 0x20, 0x30, 0x40 → outputs 0x10, 0x14, 0x1C, 0x28.
